button_conditioner: RTL and testbench
=====================================

Name: button_conditioner

Overview:
- Multi-channel successor to the single-button debouncer.
- Per channel, the block provides:
  - 2-stage synchronisation and per-channel polarity.
  - Tick-based debounce.
  - Single-cycle press and release strobes.
  - Long-press detection and optional auto-repeat.
- One shared 1 ms prescaler drives all channels.
- Sits between the board pushbuttons and the image-processor mode/control FSM, which consumes only strobes.

Parameters:
- NUM_BTNS, 5: number of independent channels.
- CLOCK_FREQ_HZ, 100_000_000: clk frequency. Must be a multiple of 1000, otherwise elaboration error.
- DEBOUNCE_TIME_MS, 20: stable time (in ms ticks) required before the level changes. Must be ≥1.
- HOLD_TIME_MS, 500: ms ticks of debounced press before btn_hold fires. Must be ≥1.
- REPEAT_TIME_MS, 100: ms ticks between btn_repeat strobes once held. Must be ≥1.
- ACTIVE_LOW_MASK, {NUM_BTNS{1'b0}}: a set bit marks that channel's raw input as active-low.

Ports:
- clk  in  1  system clock.
- reset_n  in  1  synchronous reset, active-low (fixed decision).
- btn_in  in  NUM_BTNS  raw asynchronous button pins.
- repeat_en  in  NUM_BTNS  per-channel auto-repeat enable. Sampled every cycle.
- btn_level  out  NUM_BTNS  debounced pressed state, 1 = pressed.
- btn_press  out  NUM_BTNS  1-cycle strobe on the 0→1 transition of btn_level.
- btn_release  out  NUM_BTNS  1-cycle strobe on the 1→0 transition of btn_level.
- btn_hold  out  NUM_BTNS  1-cycle strobe when the press has lasted HOLD_TIME_MS.
- btn_repeat  out  NUM_BTNS  1-cycle strobe every REPEAT_TIME_MS while held with repeat_en=1.

Behaviour:
- Reset (reset_n=0 at posedge):
  - All outputs, counters and prescaler clear to 0.
  - Every FSM goes to IDLE.
  - Sync flops load the channel's idle pin value: 1 for active-low channels, else 0. No false press follows reset release.
- Prescaler: counts 0..CLOCK_FREQ_HZ/1000-1 and wraps. ms_tick is high for 1 cycle at the wrap. It is free-running; it is not restarted by input activity.
- Synchroniser: 2 flops per channel, then XOR with ACTIVE_LOW_MASK gives sync_p (1 = pressed).
- Debounce, per channel:
  - If sync_p == btn_level, the debounce counter clears to 0 (any cycle).
  - Otherwise the counter increments on ms_tick. On the ms_tick where it reaches DEBOUNCE_TIME_MS, btn_level flips and the counter clears.
  - Resulting latency from a stable pin edge: 2 cycles + (DEBOUNCE_TIME_MS-1)…DEBOUNCE_TIME_MS ms, quantised to ticks.
- Strobes:
  - btn_press and btn_release are asserted in the same cycle btn_level takes its new value (registered together).
  - Never both in one cycle on one channel.
- FSM per channel (states IDLE, PRESSED, HELD):
  - IDLE→PRESSED on press; hold counter cleared.
  - PRESSED: hold counter increments on ms_tick. When it reaches HOLD_TIME_MS: btn_hold pulses, go to HELD, repeat counter cleared.
  - HELD: repeat counter increments on ms_tick. When it reaches REPEAT_TIME_MS and repeat_en=1: btn_repeat pulses and the counter clears.
  - HELD with repeat_en=0: counter held at 0, no strobes.
  - Any state → IDLE on release. All counters clear.
- Simultaneous events:
  - Release in the same cycle as a hold or repeat terminal tick: release wins. No hold or repeat strobe that cycle.
  - Reset wins over everything.
- Counter widths: $clog2(max+1) of the respective terminal value. No wrap past the terminal value is possible.
- Channels are fully independent. Strobes on several channels in one cycle are legal.
- Reset mid-operation: state is lost. A button still held after reset_n returns high is treated as a new press, re-entering full debounce and then the hold timing.

Decomposition:
- Package btn_cond_pkg:
  - State enum {IDLE, PRESSED, HELD}, 2 bits.
  - Function deriving the tick divisor and counter widths.
  - Elaboration-time parameter checks.
- Sub-module ms_tick_gen: the prescaler, with parameter CLOCK_FREQ_HZ and output tick. Instantiated once and shared.
- Per-channel logic in a generate loop inside button_conditioner.

Test Plan:
- Bench config for all cases: CLOCK_FREQ_HZ=10_000 (tick every 10 clk), DEBOUNCE=4, HOLD=20, REPEAT=5, NUM_BTNS=3, ACTIVE_LOW_MASK=3'b010.
- Bounce: toggle btn_in[0] every 3 clk for 90 clk, then hold at 1. Required:
  - Exactly one btn_press[0].
  - btn_level[0] rises 33–43 clk after the final edge.
  - No btn_release.
- Glitch reject: btn_in[0]=1 for 25 clk, then 0. Required: btn_level, press, release, hold and repeat all stay 0 throughout.
- Hold and repeat, repeat_en[0]=1, button held: Required:
  - btn_hold[0] exactly 200 clk after btn_press[0].
  - btn_repeat[0] at +50, +100, +150 clk after the hold.
  - On release: one btn_release[0] and no further repeats.
- No repeat, repeat_en[0]=0, same stimulus: Required: btn_hold[0] once at +200 clk; zero btn_repeat over 1000 clk.
- Active-low channel and independence. Required:
  - After reset with btn_in=3'b010, all outputs stay 0.
  - Driving btn_in[1]=0 gives btn_press[1] only. Channels 0 and 2 stay silent.
  - Releasing gives btn_release[1].
- Reset mid-hold: while ch0 is in HELD, drive reset_n=0 for 1 cycle with the button still pressed. Required:
  - All outputs are 0 the cycle after.
  - btn_press[0] recurs 33–43 clk later.
  - btn_hold[0] follows 200 clk after that press.

Source files
------------

// File: rtl/btn_cond_pkg.sv
// Shared types and elaboration helpers for the multi-channel button conditioner.
package btn_cond_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        PRESSED = 2'd1,
        HELD    = 2'd2
    } btn_state_e;

    // Clock cycles per 1 ms tick.
    function automatic int unsigned tick_div(input int unsigned clock_freq_hz);
        return clock_freq_hz / 1000;
    endfunction

    // Bits needed to hold 0..max_val; never narrower than one bit.
    function automatic int unsigned cnt_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

    function automatic bit params_ok(input int unsigned clock_freq_hz,
                                     input int unsigned debounce_ms,
                                     input int unsigned hold_ms,
                                     input int unsigned repeat_ms);
        return (clock_freq_hz >= 1000) && (clock_freq_hz % 1000 == 0) &&
               (debounce_ms >= 1) && (hold_ms >= 1) && (repeat_ms >= 1);
    endfunction

endpackage

// File: rtl/button_conditioner_ms_tick_gen.sv
// Free-running 1 ms prescaler; one tick pulse per wrap, shared by all channels.
module ms_tick_gen
    import btn_cond_pkg::*;
#(
    parameter int unsigned CLOCK_FREQ_HZ = 100_000_000
) (
    input  logic clk,
    input  logic reset_n,
    output logic tick
);

    localparam int unsigned DIV = tick_div(CLOCK_FREQ_HZ);
    localparam int unsigned CW  = cnt_width(DIV - 1);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign tick  = (cnt_q == LAST);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

endmodule

// File: rtl/button_conditioner.sv
// Per-channel synchroniser, tick debouncer, press/release strobes and hold/auto-repeat FSM.
module button_conditioner
    import btn_cond_pkg::*;
#(
    parameter int unsigned NUM_BTNS         = 5,
    parameter int unsigned CLOCK_FREQ_HZ    = 100_000_000,
    parameter int unsigned DEBOUNCE_TIME_MS = 20,
    parameter int unsigned HOLD_TIME_MS     = 500,
    parameter int unsigned REPEAT_TIME_MS   = 100,
    parameter logic [NUM_BTNS-1:0] ACTIVE_LOW_MASK = {NUM_BTNS{1'b0}}
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic [NUM_BTNS-1:0] btn_in,
    input  logic [NUM_BTNS-1:0] repeat_en,
    output logic [NUM_BTNS-1:0] btn_level,
    output logic [NUM_BTNS-1:0] btn_press,
    output logic [NUM_BTNS-1:0] btn_release,
    output logic [NUM_BTNS-1:0] btn_hold,
    output logic [NUM_BTNS-1:0] btn_repeat
);

    localparam int unsigned DEB_W  = cnt_width(DEBOUNCE_TIME_MS);
    localparam int unsigned HOLD_W = cnt_width(HOLD_TIME_MS);
    localparam int unsigned REP_W  = cnt_width(REPEAT_TIME_MS);
    localparam logic [DEB_W-1:0]  DEB_TERM  = DEB_W'(DEBOUNCE_TIME_MS);
    localparam logic [HOLD_W-1:0] HOLD_TERM = HOLD_W'(HOLD_TIME_MS);
    localparam logic [REP_W-1:0]  REP_TERM  = REP_W'(REPEAT_TIME_MS);

    if (!params_ok(CLOCK_FREQ_HZ, DEBOUNCE_TIME_MS, HOLD_TIME_MS, REPEAT_TIME_MS)) begin : g_param_check
        $error("button_conditioner: CLOCK_FREQ_HZ must be a multiple of 1000 and all times >= 1");
    end

    logic tick;

    ms_tick_gen #(
        .CLOCK_FREQ_HZ(CLOCK_FREQ_HZ)
    ) u_ms_tick (
        .clk    (clk),
        .reset_n(reset_n),
        .tick   (tick)
    );

    for (genvar g = 0; g < NUM_BTNS; g++) begin : g_ch
        logic              sync1_q, sync2_q, sync_p;
        logic              level_q, level_d;
        logic              press_q, press_d, release_q, release_d;
        logic              hold_q, hold_d, repeat_q, repeat_d;
        logic [DEB_W-1:0]  deb_cnt_q, deb_cnt_d, deb_inc;
        logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d, hold_inc;
        logic [REP_W-1:0]  rep_cnt_q, rep_cnt_d, rep_inc;
        btn_state_e        state_q, state_d;

        assign sync_p   = sync2_q ^ ACTIVE_LOW_MASK[g];
        assign deb_inc  = deb_cnt_q + 1'b1;
        assign hold_inc = hold_cnt_q + 1'b1;
        assign rep_inc  = rep_cnt_q + 1'b1;

        // NOTE: every always_comb output gets a default first, so no path can infer a latch.
        always_comb begin
            level_d   = level_q;
            deb_cnt_d = deb_cnt_q;
            press_d   = 1'b0;
            release_d = 1'b0;
            if (sync_p == level_q) begin
                deb_cnt_d = '0;
            end else if (tick) begin
                if (deb_inc == DEB_TERM) begin
                    level_d   = ~level_q;
                    deb_cnt_d = '0;
                    press_d   = ~level_q;
                    release_d = level_q;
                end else begin
                    deb_cnt_d = deb_inc;
                end
            end
        end

        // Release is handled ahead of the state case so it beats a coincident hold/repeat tick.
        always_comb begin
            state_d    = state_q;
            hold_cnt_d = hold_cnt_q;
            rep_cnt_d  = rep_cnt_q;
            hold_d     = 1'b0;
            repeat_d   = 1'b0;
            if (release_d) begin
                state_d    = IDLE;
                hold_cnt_d = '0;
                rep_cnt_d  = '0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (press_d) begin
                            state_d    = PRESSED;
                            hold_cnt_d = '0;
                        end
                    end
                    PRESSED: begin
                        if (tick) begin
                            if (hold_inc == HOLD_TERM) begin
                                hold_d     = 1'b1;
                                state_d    = HELD;
                                hold_cnt_d = '0;
                                rep_cnt_d  = '0;
                            end else begin
                                hold_cnt_d = hold_inc;
                            end
                        end
                    end
                    HELD: begin
                        if (!repeat_en[g]) begin
                            rep_cnt_d = '0;
                        end else if (tick) begin
                            if (rep_inc == REP_TERM) begin
                                repeat_d  = 1'b1;
                                rep_cnt_d = '0;
                            end else begin
                                rep_cnt_d = rep_inc;
                            end
                        end
                    end
                    default: begin
                        state_d    = IDLE;
                        hold_cnt_d = '0;
                        rep_cnt_d  = '0;
                    end
                endcase
            end
        end

        // Sync flops reset to the idle pin level so releasing reset never looks like an edge.
        always_ff @(posedge clk) begin
            if (!reset_n) begin
                sync1_q    <= ACTIVE_LOW_MASK[g];
                sync2_q    <= ACTIVE_LOW_MASK[g];
                level_q    <= 1'b0;
                deb_cnt_q  <= '0;
                press_q    <= 1'b0;
                release_q  <= 1'b0;
                hold_q     <= 1'b0;
                repeat_q   <= 1'b0;
                hold_cnt_q <= '0;
                rep_cnt_q  <= '0;
                state_q    <= IDLE;
            end else begin
                sync1_q    <= btn_in[g];
                sync2_q    <= sync1_q;
                level_q    <= level_d;
                deb_cnt_q  <= deb_cnt_d;
                press_q    <= press_d;
                release_q  <= release_d;
                hold_q     <= hold_d;
                repeat_q   <= repeat_d;
                hold_cnt_q <= hold_cnt_d;
                rep_cnt_q  <= rep_cnt_d;
                state_q    <= state_d;
            end
        end

        assign btn_level[g]   = level_q;
        assign btn_press[g]   = press_q;
        assign btn_release[g] = release_q;
        assign btn_hold[g]    = hold_q;
        assign btn_repeat[g]  = repeat_q;
    end

endmodule

// File: tb/tb_button_conditioner.sv
// Self-checking bench: vector table, directed corner sequences and a random phase against a tick-index model.
module tb_button_conditioner;

    localparam int NB = 3;
    localparam int unsigned CLK_HZ = 10_000;
    localparam int unsigned DIV  = CLK_HZ / 1000;
    localparam int unsigned DEB  = 4;
    localparam int unsigned HOLD = 20;
    localparam int unsigned REP  = 5;
    localparam logic [NB-1:0] MASK      = 3'b010;
    localparam logic [NB-1:0] IDLE_PINS = 3'b010;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [NB-1:0] btn_in = IDLE_PINS;
    logic [NB-1:0] repeat_en = '0;
    logic [NB-1:0] btn_level, btn_press, btn_release, btn_hold, btn_repeat;

    always #5 clk = ~clk;

    button_conditioner #(
        .NUM_BTNS        (NB),
        .CLOCK_FREQ_HZ   (CLK_HZ),
        .DEBOUNCE_TIME_MS(DEB),
        .HOLD_TIME_MS    (HOLD),
        .REPEAT_TIME_MS  (REP),
        .ACTIVE_LOW_MASK (MASK)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .btn_in     (btn_in),
        .repeat_en  (repeat_en),
        .btn_level  (btn_level),
        .btn_press  (btn_press),
        .btn_release(btn_release),
        .btn_hold   (btn_hold),
        .btn_repeat (btn_repeat)
    );

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- monitor state ----------------
    int unsigned cyc = 0;
    int n_press[NB]   = '{default: 0};
    int n_release[NB] = '{default: 0};
    int n_hold[NB]    = '{default: 0};
    int n_repeat[NB]  = '{default: 0};
    int n_lvl_hi[NB]  = '{default: 0};
    int n_any[NB]     = '{default: 0};
    int t_press[NB]   = '{default: 0};
    int t_release[NB] = '{default: 0};
    int t_hold[NB]    = '{default: 0};
    int rep_t[$];

    // ---------------- reference model ----------------
    // Level changes once DEB ms ticks have elapsed in an unbroken disagreement run;
    // hold and repeat are derived from the tick index elapsed since the press.
    int unsigned   m_n, m_k;
    logic [NB-1:0] m_p1, m_p2, m_lvl;
    bit            m_run[NB];
    int unsigned   m_run_k0[NB];
    bit            m_down[NB];
    int unsigned   m_press_k[NB];
    logic [NB-1:0] e_press, e_rel, e_hold, e_rep;

    task automatic model_step();
        int unsigned tk, k_now, since;
        logic sp;
        e_press = '0; e_rel = '0; e_hold = '0; e_rep = '0;
        if (!reset_n) begin
            m_n = 0; m_k = 0; m_p1 = MASK; m_p2 = MASK; m_lvl = '0;
            for (int c = 0; c < NB; c++) begin m_run[c] = 0; m_down[c] = 0; end
        end else begin
            m_n++;
            tk    = (m_n % DIV == 0) ? 1 : 0;
            k_now = m_k + tk;
            for (int c = 0; c < NB; c++) begin
                sp = m_p2[c] ^ MASK[c];
                if (sp == m_lvl[c]) begin
                    m_run[c] = 0;
                end else begin
                    if (!m_run[c]) begin m_run[c] = 1; m_run_k0[c] = m_k; end
                    if (k_now - m_run_k0[c] == DEB) begin
                        m_run[c] = 0;
                        m_lvl[c] = ~m_lvl[c];
                        if (m_lvl[c]) begin e_press[c] = 1'b1; m_down[c] = 1; m_press_k[c] = k_now; end
                        else begin e_rel[c] = 1'b1; m_down[c] = 0; end
                    end
                end
                if (m_down[c] && tk == 1) begin
                    since = k_now - m_press_k[c];
                    if (since == HOLD) e_hold[c] = 1'b1;
                    else if (since > HOLD && repeat_en[c] && (since - HOLD) % REP == 0) e_rep[c] = 1'b1;
                end
            end
            m_k  = k_now;
            m_p2 = m_p1;
            m_p1 = btn_in;
        end
    endtask

    task automatic monitor();
        for (int c = 0; c < NB; c++) begin
            if (btn_press[c])   begin n_press[c]++;   t_press[c] = cyc;   end
            if (btn_release[c]) begin n_release[c]++; t_release[c] = cyc; end
            if (btn_hold[c])    begin n_hold[c]++;    t_hold[c] = cyc;    end
            if (btn_repeat[c])  begin n_repeat[c]++;  if (c == 0) rep_t.push_back(cyc); end
            if (btn_level[c])   n_lvl_hi[c]++;
            if (btn_level[c] | btn_press[c] | btn_release[c] | btn_hold[c] | btn_repeat[c]) n_any[c]++;
        end
    endtask

    // One clock: model follows the edge, DUT is sampled and compared on the falling edge.
    task automatic cycle();
        @(posedge clk);
        model_step();
        cyc++;
        @(negedge clk);
        monitor();
        check("model", {btn_level, btn_press, btn_release, btn_hold, btn_repeat},
                       {m_lvl, e_press, e_rel, e_hold, e_rep});
    endtask

    task automatic run(input int n);
        repeat (n) cycle();
    endtask

    task automatic do_reset(input logic [NB-1:0] pins, input logic [NB-1:0] ren);
        btn_in = pins; repeat_en = ren; reset_n = 1'b0;
        cycle();
        reset_n = 1'b1;
    endtask

    // Bounded wait for a press strobe on channel c; returns its cycle.
    task automatic wait_press(input int c, input int base, output int t);
        int k = 0;
        while (n_press[c] == base && k < 80) begin cycle(); k++; end
        check("press_seen", (n_press[c] != base) ? 1 : 0, 1);
        t = t_press[c];
    endtask

    typedef struct {
        logic [NB-1:0] pins;
        int            cycles;
        logic [NB-1:0] lvl;
    } vec_t;

    vec_t vecs[11];

    initial begin
        int b_press, b_rel, b_hold, b_rep, b_lvl, b_any0, b_any1, b_any2, rb, tp, t0, t_rst, lat;

        vecs[0]  = '{3'b010, 40, 3'b000};
        vecs[1]  = '{3'b011, 20, 3'b000};
        vecs[2]  = '{3'b011, 50, 3'b001};
        vecs[3]  = '{3'b001, 60, 3'b011};
        vecs[4]  = '{3'b101, 60, 3'b111};
        vecs[5]  = '{3'b111, 60, 3'b101};
        vecs[6]  = '{3'b110, 60, 3'b100};
        vecs[7]  = '{3'b010, 60, 3'b000};
        vecs[8]  = '{3'b000, 10, 3'b000};
        vecs[9]  = '{3'b000, 50, 3'b010};
        vecs[10] = '{3'b010, 60, 3'b000};

        // Reset state
        do_reset(IDLE_PINS, '0);
        check("reset_outputs", {btn_level, btn_press, btn_release, btn_hold, btn_repeat}, '0);

        // Vector table: level after each pin pattern has been applied for the given time
        for (int i = 0; i < 11; i++) begin
            btn_in = vecs[i].pins;
            run(vecs[i].cycles);
            check($sformatf("vec%0d_level", i), btn_level, vecs[i].lvl);
        end

        // Bounce: toggle every 3 clk for 90 clk, then settle high
        do_reset(IDLE_PINS, '0);
        b_press = n_press[0]; b_rel = n_release[0];
        for (int i = 0; i < 30; i++) begin btn_in[0] = ~btn_in[0]; run(3); end
        btn_in[0] = 1'b1;
        t0 = cyc;
        wait_press(0, b_press, tp);
        lat = tp - t0;
        check("bounce_latency_33_43", (lat >= 33 && lat <= 43) ? 1 : 0, 1);
        run(20);
        check("bounce_press_count", n_press[0] - b_press, 1);
        check("bounce_no_release", n_release[0] - b_rel, 0);

        // Glitch reject: 25 clk high pulse
        do_reset(IDLE_PINS, '0);
        b_press = n_press[0]; b_rel = n_release[0]; b_hold = n_hold[0]; b_rep = n_repeat[0]; b_lvl = n_lvl_hi[0];
        btn_in[0] = 1'b1; run(25);
        btn_in[0] = 1'b0; run(80);
        check("glitch_level", n_lvl_hi[0] - b_lvl, 0);
        check("glitch_press", n_press[0] - b_press, 0);
        check("glitch_release", n_release[0] - b_rel, 0);
        check("glitch_hold", n_hold[0] - b_hold, 0);
        check("glitch_repeat", n_repeat[0] - b_rep, 0);

        // Hold and auto-repeat
        do_reset(IDLE_PINS, 3'b001);
        b_press = n_press[0]; b_rel = n_release[0]; b_hold = n_hold[0]; b_rep = n_repeat[0]; rb = rep_t.size();
        btn_in[0] = 1'b1;
        wait_press(0, b_press, tp);
        run(355);
        btn_in[0] = 1'b0;
        run(120);
        check("hold_count", n_hold[0] - b_hold, 1);
        check("hold_delay", t_hold[0] - tp, 200);
        check("repeat_count", n_repeat[0] - b_rep, 3);
        for (int i = 0; i < 3; i++)
            if (rep_t.size() > rb + i)
                check($sformatf("repeat%0d_delay", i), rep_t[rb + i] - t_hold[0], 50 * (i + 1));
        check("release_count", n_release[0] - b_rel, 1);

        // Held without repeat enable
        do_reset(IDLE_PINS, 3'b000);
        b_press = n_press[0]; b_hold = n_hold[0]; b_rep = n_repeat[0];
        btn_in[0] = 1'b1;
        wait_press(0, b_press, tp);
        run(1000);
        check("norep_hold_count", n_hold[0] - b_hold, 1);
        check("norep_hold_delay", t_hold[0] - tp, 200);
        check("norep_repeat_count", n_repeat[0] - b_rep, 0);
        btn_in[0] = 1'b0; run(60);

        // Active-low channel and channel independence
        do_reset(IDLE_PINS, 3'b000);
        b_any0 = n_any[0]; b_any1 = n_any[1]; b_any2 = n_any[2];
        run(100);
        check("al_idle_silent", (n_any[0] - b_any0) + (n_any[1] - b_any1) + (n_any[2] - b_any2), 0);
        b_press = n_press[1]; b_rel = n_release[1];
        btn_in[1] = 1'b0; run(60);
        check("al_press1", n_press[1] - b_press, 1);
        check("al_level1", btn_level, 3'b010);
        btn_in[1] = 1'b1; run(60);
        check("al_release1", n_release[1] - b_rel, 1);
        check("al_others_silent", (n_any[0] - b_any0) + (n_any[2] - b_any2), 0);

        // Reset while held
        do_reset(IDLE_PINS, 3'b001);
        b_press = n_press[0];
        btn_in[0] = 1'b1;
        wait_press(0, b_press, tp);
        run(230);
        reset_n = 1'b0;
        cycle();
        t_rst = cyc;
        reset_n = 1'b1;
        check("midreset_outputs", {btn_level, btn_press, btn_release, btn_hold, btn_repeat}, '0);
        b_press = n_press[0]; b_hold = n_hold[0];
        wait_press(0, b_press, tp);
        lat = tp - t_rst;
        check("midreset_repress_33_43", (lat >= 33 && lat <= 43) ? 1 : 0, 1);
        run(205);
        check("midreset_hold_count", n_hold[0] - b_hold, 1);
        check("midreset_hold_delay", t_hold[0] - tp, 200);

        // Random phase: the per-cycle model comparison inside cycle() does the checking
        for (int seg = 0; seg < 4; seg++) begin
            do_reset(IDLE_PINS, NB'($urandom));
            for (int s = 0; s < 30; s++) begin
                int c, cls, dur;
                c   = $urandom_range(0, NB - 1);
                cls = $urandom_range(0, 2);
                dur = (cls == 0) ? $urandom_range(1, 6) : (cls == 1) ? $urandom_range(30, 80) : $urandom_range(150, 350);
                btn_in[c] = ~btn_in[c];
                run(dur);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
